fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Owns the single framebuffer RAM port and sequences each frame. Two game-side writers share the port in IDLE under round-robin arbitration. On each frame tick the port is handed to the screen flasher, which drives its continuation handshake (start, done, ack). The block sits between the game logic, the framebuffer RAM and `screenFlash`, and drives the flasher's `in_cont_signal` and `next_fin_signal`.

## Interface
- `ADDR_W`, default `` `MEMORY_SIZE_BITS ``: framebuffer address width.
- `DATA_W`, default `` `COLOR_SIZE ``: pixel width.
- `FCNT_W`, default 8: frame counter width.

- `Clck`  in  1  the single clock, all logic on posedge.
- `Reset`  in  1  synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse requesting a screen refresh.
- `wr_req_a` / `wr_req_b`  in  1  writer A/B write request, held until granted.
- `wr_addr_a` / `wr_addr_b`  in  ADDR_W  write address.
- `wr_data_a` / `wr_data_b`  in  DATA_W  write pixel.
- `wr_gnt_a` / `wr_gnt_b`  out  1  combinational; high in the cycle the write is performed.
- `flash_addr`  in  ADDR_W  flasher read address.
- `flash_data`  out  DATA_W  `mem_rdata` passed through.
- `flash_start`  out  1  flasher continuation start (to `in_cont_signal`).
- `flash_done`  in  1  flasher finished (from `out_cont_signal`).
- `flash_ack`  out  1  continuation acknowledge (to `next_fin_signal`).
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_rdata`  in  DATA_W  RAM read data, registered RAM with 1-cycle latency.
- `frame_busy`  out  1  high in FLASH or ACK.
- `frame_count`  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W.
- `overrun`  out  1  sticky; a tick arrived while a tick was already pending.

## Operation
- **States:**
  - IDLE: writers own the port.
  - FLASH: `flash_start` is high; the flasher owns the port.
  - ACK: `flash_ack` is high; waits for `flash_done` to drop.
- **IDLE:**
  - If exactly one `wr_req` is high, grant it.
  - If both are high, grant the requester not granted last. `last` resets to B, so A wins the first tie.
  - On a grant: `mem_we`=1, and `mem_addr`/`mem_wdata` come from the granted writer.
  - With no grant: `mem_we`=0, `mem_addr`=0.
- **FLASH:** `mem_addr`=`flash_addr`, `mem_we`=0, both grants 0.
- **Transitions:**
  - IDLE→FLASH when `frame_tick` or `tick_pending` is high. Writes are still granted in that cycle. `tick_pending` clears.
  - FLASH→ACK when `flash_done`=1.
  - ACK→IDLE when `flash_done`=0. `frame_count` increments on this transition.
- **Tick handling:**
  - A `frame_tick` in FLASH or ACK sets `tick_pending`.
  - A tick while `tick_pending` is already 1 sets `overrun`. Only one refresh is queued.
  - The pending tick restarts FLASH on the cycle after the return to IDLE. This guarantees one full IDLE cycle for the writers.
- **Reset (any state, including mid-flash):** state=IDLE; `flash_start`, `flash_ack`, `tick_pending`, `overrun` = 0; `frame_count`=0; `last`=B.

## Timing
- `flash_start`, `flash_ack` and `frame_busy` are registered decodes of the state. `flash_start` rises the cycle after the IDLE→FLASH decision.
- Grants and the memory mux are combinational from state and requests. A write lands on the edge closing its grant cycle; the writer must update `req`/`addr`/`data` after that edge.
- The read path is zero-cycle combinational (`flash_data` = `mem_rdata`). The flasher's one-cycle gap between address and plot covers the RAM latency.
- ACK lasts at least 1 cycle. `flash_start` is 0 in ACK, so the flasher clears `out_cont_signal` on the next edge.
- Writer latency under contention: at most 2 IDLE cycles with round-robin, excluding FLASH time.

## Structure
- The existing shared header supplies `` `MEMORY_SIZE_BITS ``, `` `COLOR_SIZE ``, and new `` `FB_FCNT_BITS `` (8).
- State encodings are localparams in the block.
- One sub-module: `rr_arb2`, a 2-way round-robin with `last` register. Inputs: `req[1:0]`, `enable`. Output: one-hot `gnt[1:0]`.

## Test plan
- **Tie:** `Reset`, then `wr_req_a`=`wr_req_b`=1 for 4 cycles, addresses 0x10/0x20 -> grants A,B,A,B; `mem_we`=1 each cycle; `mem_addr` 0x10,0x20,0x10,0x20.
- **Frame:** `frame_tick` with `wr_req_a` high -> A granted that cycle; then FLASH, `flash_start`=1, `mem_addr` follows `flash_addr`, no grants. `flash_done`=1 -> ACK with `flash_ack`=1. `flash_done`=0 -> IDLE, `frame_count`=1.
- **Tick during FLASH:** one tick -> `tick_pending`; exactly one IDLE cycle after ACK, then FLASH again; `overrun`=0. Two ticks during FLASH -> `overrun`=1 and stays 1.
- **Reset mid-FLASH:** `Reset` high 1 cycle -> next cycle IDLE, `flash_start`=0, `frame_count`=0, `overrun`=0.
- **Wrap:** 256 complete frames -> `frame_count` wraps 255→0.

Source files
------------

// File: rtl/fb_port_arbiter_pkg.sv
// Shared widths and the round-robin pick used by the framebuffer port arbiter.
// The shared header normally supplies these macros; fall back to sane widths
// when this slice is built on its own.
`ifndef MEMORY_SIZE_BITS
`define MEMORY_SIZE_BITS 12
`endif
`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif
`ifndef FB_FCNT_BITS
`define FB_FCNT_BITS 8
`endif

package fb_port_arbiter_pkg;

  localparam int FB_ADDR_W = `MEMORY_SIZE_BITS;
  localparam int FB_DATA_W = `COLOR_SIZE;
  localparam int FB_FCNT_W = `FB_FCNT_BITS;

  // Bit positions inside the two-way request/grant vectors
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  // One-hot grant for a two-way round robin: on a tie the requester that was
  // not served last wins, otherwise the lone requester is passed through
  function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic last_b);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_b ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter remembering which side was granted last.
module rr_arb2
  import fb_port_arbiter_pkg::*;
(
  input  logic       Clck,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_b;

  // Grant is purely combinational so the write lands in the request cycle
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      gnt = rr_grant(req, last_b);
    end
  end

  // Track the last winner; reset to B so A wins the first tie
  always_ff @(posedge Clck) begin
    if (Reset) begin
      last_b <= 1'b1;
    end else if (gnt[REQ_A]) begin
      last_b <= 1'b0;
    end else if (gnt[REQ_B]) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port owner: writers share the port in IDLE, the screen
// flasher takes it for each frame and is sequenced through start/ack.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int FCNT_W = FB_FCNT_W
) (
  input  logic              Clck,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              wr_req_a,
  input  logic              wr_req_b,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic              wr_gnt_a,
  output logic              wr_gnt_b,
  input  logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_data,
  output logic              flash_start,
  input  logic              flash_done,
  output logic              flash_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_busy,
  output logic [FCNT_W-1:0] frame_count,
  output logic              overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLASH = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       tick_pending;
  logic [1:0] gnt;
  logic       in_idle;

  assign in_idle = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .Clck   (Clck),
    .Reset  (Reset),
    .req    ({wr_req_b, wr_req_a}),
    .enable (in_idle),
    .gnt    (gnt)
  );

  // Reads go straight through; the flasher's address-to-plot gap hides RAM latency
  assign flash_data = mem_rdata;

  // State register
  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a fresh or queued tick starts a flash, done/!done walk through ACK
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_tick || tick_pending) state_d = ST_FLASH;
      ST_FLASH: if (flash_done)                 state_d = ST_ACK;
      ST_ACK:   if (!flash_done)                state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  // Port mux: granted writer in IDLE, flasher address otherwise
  always_comb begin
    wr_gnt_a  = gnt[REQ_A];
    wr_gnt_b  = gnt[REQ_B];
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!in_idle) begin
      mem_addr = flash_addr;
    end else if (gnt[REQ_A]) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr_a;
      mem_wdata = wr_data_a;
    end else if (gnt[REQ_B]) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr_b;
      mem_wdata = wr_data_b;
    end
  end

  // Registered handshake decodes so they line up with the state they describe
  always_ff @(posedge Clck) begin
    if (Reset) begin
      flash_start <= 1'b0;
      flash_ack   <= 1'b0;
      frame_busy  <= 1'b0;
    end else begin
      flash_start <= (state_d == ST_FLASH);
      flash_ack   <= (state_d == ST_ACK);
      frame_busy  <= (state_d == ST_FLASH) || (state_d == ST_ACK);
    end
  end

  // Queue at most one refresh tick while busy; a second one is flagged as overrun
  always_ff @(posedge Clck) begin
    if (Reset) begin
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else if (in_idle) begin
      if (state_d == ST_FLASH) begin
        tick_pending <= 1'b0;
      end
    end else if (frame_tick) begin
      tick_pending <= 1'b1;
      if (tick_pending) begin
        overrun <= 1'b1;
      end
    end
  end

  // Count frames as the flasher releases the port
  always_ff @(posedge Clck) begin
    if (Reset) begin
      frame_count <= '0;
    end else if (state_q == ST_ACK && !flash_done) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Vector table plus hand sequences for fb_port_arbiter.
module tb_fb_port_arbiter;
  import fb_port_arbiter_pkg::*;

  localparam int AW = FB_ADDR_W;
  localparam int DW = FB_DATA_W;
  localparam int CW = FB_FCNT_W;

  logic          Clck = 1'b0;
  logic          Reset;
  logic          frame_tick, wr_req_a, wr_req_b, flash_done;
  logic [AW-1:0] wr_addr_a, wr_addr_b, flash_addr, mem_addr;
  logic [DW-1:0] wr_data_a, wr_data_b, flash_data, mem_wdata, mem_rdata;
  logic          wr_gnt_a, wr_gnt_b, flash_start, flash_ack, mem_we, frame_busy, overrun;
  logic [CW-1:0] frame_count;

  fb_port_arbiter dut (
    .Clck(Clck), .Reset(Reset), .frame_tick(frame_tick),
    .wr_req_a(wr_req_a), .wr_req_b(wr_req_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .wr_gnt_a(wr_gnt_a), .wr_gnt_b(wr_gnt_b),
    .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_start(flash_start), .flash_done(flash_done), .flash_ack(flash_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .frame_busy(frame_busy), .frame_count(frame_count), .overrun(overrun)
  );

  always #5 Clck = ~Clck;

  typedef struct {
    int rst, ra, rb, aa, da, ab, db, tk, dn, fa, rd;
    int ga, gb, we, ea, ew, st, ak, bz, fc, ov;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  // Record one comparison; -1 as expectation means "not checked"
  task automatic cmp(input string name, input int act, input int exp);
    if (exp < 0) return;
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic addVec(input int rst, ra, rb, aa, da, ab, db, tk, dn, fa,
                        input int ga, gb, we, ea, ew, st, ak, bz, fc, ov);
    vec_t v;
    v.rst = rst; v.ra = ra; v.rb = rb; v.aa = aa; v.da = da; v.ab = ab; v.db = db;
    v.tk = tk; v.dn = dn; v.fa = fa; v.rd = (vecs.size() * 37 + 11) % 256;
    v.ga = ga; v.gb = gb; v.we = we; v.ea = ea; v.ew = ew;
    v.st = st; v.ak = ak; v.bz = bz; v.fc = fc; v.ov = ov;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and queue what the DUT must show for it
  task automatic applyStimulus(input vec_t v);
    Reset      = v.rst[0];
    wr_req_a   = v.ra[0];
    wr_req_b   = v.rb[0];
    wr_addr_a  = v.aa[AW-1:0];
    wr_data_a  = v.da[DW-1:0];
    wr_addr_b  = v.ab[AW-1:0];
    wr_data_b  = v.db[DW-1:0];
    frame_tick = v.tk[0];
    flash_done = v.dn[0];
    flash_addr = v.fa[AW-1:0];
    mem_rdata  = v.rd[DW-1:0];
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    string p;
    if (expQ.size() == 0) begin
      cmp("scoreboard_empty", 1, 0);
      return;
    end
    e = expQ.pop_front();
    p = $sformatf("v%0d_", idx);
    cmp({p, "gnt_a"},      int'(wr_gnt_a), e.ga);
    cmp({p, "gnt_b"},      int'(wr_gnt_b), e.gb);
    cmp({p, "mem_we"},     int'(mem_we), e.we);
    cmp({p, "mem_addr"},   int'(mem_addr), e.ea);
    cmp({p, "mem_wdata"},  int'(mem_wdata), e.ew);
    cmp({p, "start"},      int'(flash_start), e.st);
    cmp({p, "ack"},        int'(flash_ack), e.ak);
    cmp({p, "busy"},       int'(frame_busy), e.bz);
    cmp({p, "frame_count"},int'(frame_count), e.fc);
    cmp({p, "overrun"},    int'(overrun), e.ov);
    cmp({p, "flash_data"}, int'(flash_data), e.rd);
  endtask

  task automatic idleInputs();
    Reset = 0; frame_tick = 0; wr_req_a = 0; wr_req_b = 0; flash_done = 0;
    wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
    flash_addr = '0; mem_rdata = '0;
  endtask

  int missedStart;

  initial begin
    //     rst ra rb aa    da    ab    db    tk dn fa      ga gb we ea    ew    st ak bz fc ov
    // Tie: A,B,A,B
    addVec(0, 1, 1, 'h10, 'hA1, 'h20, 'hB2, 0, 0, 0,      1, 0, 1, 'h10, 'hA1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 'h10, 'hA1, 'h20, 'hB2, 0, 0, 0,      0, 1, 1, 'h20, 'hB2, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 'h10, 'hA1, 'h20, 'hB2, 0, 0, 0,      1, 0, 1, 'h10, 'hA1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 'h10, 'hA1, 'h20, 'hB2, 0, 0, 0,      0, 1, 1, 'h20, 'hB2, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 0, 'h3FF,  0, 0, 0, 0,    -1,   0, 0, 0, 0, 0);
    // Frame: tick with A requesting, FLASH, ACK, back to IDLE
    addVec(0, 1, 0, 'h33, 'hC3, 0,    0,    1, 0, 0,      1, 0, 1, 'h33, 'hC3, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 'h33, 'hC3, 0,    0,    0, 0, 'h55,   0, 0, 0, 'h55, -1,   1, 0, 1, 0, 0);
    addVec(0, 1, 0, 'h33, 'hC3, 0,    0,    0, 1, 'h56,   0, 0, 0, 'h56, -1,   1, 0, 1, 0, 0);
    addVec(0, 1, 0, 'h33, 'hC3, 0,    0,    0, 0, 'h57,   0, 0, 0, -1,   -1,   0, 1, 1, 0, 0);
    addVec(0, 1, 0, 'h34, 'h5A, 0,    0,    0, 0, 0,      1, 0, 1, 'h34, 'h5A, 0, 0, 0, 1, 0);
    // One tick during FLASH: single IDLE cycle then FLASH again
    addVec(0, 0, 0, 0,    0,    0,    0,    1, 0, 0,      0, 0, 0, 0,    -1,   0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0,    0,    0,    0,    1, 0, 'h60,   0, 0, 0, 'h60, -1,   1, 0, 1, 1, 0);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 1, 'h61,   0, 0, 0, 'h61, -1,   1, 0, 1, 1, 0);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 0, 0,      0, 0, 0, -1,   -1,   0, 1, 1, 1, 0);
    addVec(0, 0, 1, 0,    0,    'h44, 'hD4, 0, 0, 0,      0, 1, 1, 'h44, 'hD4, 0, 0, 0, 2, 0);
    // Two ticks during FLASH: overrun sticks
    addVec(0, 0, 1, 0,    0,    'h44, 'hD4, 1, 0, 'h70,   0, 0, 0, 'h70, -1,   1, 0, 1, 2, 0);
    addVec(0, 0, 0, 0,    0,    0,    0,    1, 0, 'h71,   0, 0, 0, 'h71, -1,   1, 0, 1, 2, 0);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 1, 'h72,   0, 0, 0, 'h72, -1,   1, 0, 1, 2, 1);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 0, 0,      0, 0, 0, -1,   -1,   0, 1, 1, 2, 1);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 0, 0,      0, 0, 0, 0,    -1,   0, 0, 0, 3, 1);
    addVec(0, 0, 0, 0,    0,    0,    0,    0, 0, 'h80,   0, 0, 0, 'h80, -1,   1, 0, 1, 3, 1);
    // Reset mid-FLASH, then the tie goes back to A first
    addVec(1, 0, 0, 0,    0,    0,    0,    0, 0, 'h81,   0, 0, 0, 'h81, -1,   1, 0, 1, 3, 1);
    addVec(0, 1, 1, 'h10, 'hA1, 'h20, 'hB2, 0, 0, 0,      1, 0, 1, 'h10, 'hA1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 'h10, 'hA1, 'h20, 'hB2, 0, 0, 0,      0, 1, 1, 'h20, 'hB2, 0, 0, 0, 0, 0);

    idleInputs();
    Reset = 1;
    repeat (2) @(posedge Clck);
    #1 Reset = 0;
    @(negedge Clck);
    cmp("reset_start",  int'(flash_start), 0);
    cmp("reset_ack",    int'(flash_ack), 0);
    cmp("reset_busy",   int'(frame_busy), 0);
    cmp("reset_count",  int'(frame_count), 0);
    cmp("reset_overrun",int'(overrun), 0);
    cmp("reset_we",     int'(mem_we), 0);
    cmp("reset_addr",   int'(mem_addr), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clck);
      #1 applyStimulus(vecs[i]);
      @(negedge Clck);
      checkOutput(i);
    end
    cmp("scoreboard_drained", expQ.size(), 0);

    // Frame counter wrap: 256 complete frames from a freshly reset count
    @(posedge Clck);
    #1 idleInputs();
    missedStart = 0;
    for (int f = 1; f <= 256; f++) begin
      @(posedge Clck); #1 frame_tick = 1;
      @(posedge Clck); #1 frame_tick = 0; flash_done = 1;
      @(negedge Clck);
      if (!flash_start) missedStart++;
      @(posedge Clck); #1 flash_done = 0;
      @(posedge Clck); #1;
      @(negedge Clck);
      if (f == 255) cmp("wrap_count_255", int'(frame_count), 255);
      if (f == 256) cmp("wrap_count_0",   int'(frame_count), 0);
    end
    cmp("wrap_starts_seen", missedStart, 0);
    cmp("wrap_no_overrun",  int'(overrun), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
